// File: rtl/serial_router_system.sv
// Pushbutton-stepped serial demultiplexer.
// A frame is a start bit (0), a 2-bit port address, a 4-bit count N and then
// N data bits. Data bits are routed live to the addressed output p0..p3.
// Two seven-segment digits show the remaining count and the selected port.
module serial_router_system #(
    parameter int SYNC_STAGES = 2,
    parameter int SSD_ACT_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkPB,
    input  logic       ser_in,
    output logic       p0,
    output logic       p1,
    output logic       p2,
    output logic       p3,
    output logic       SerOutValid,
    output logic       done,
    output logic [6:0] SSD1,
    output logic [6:0] SSD2
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PORT  = 3'd1,
        COUNT = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic                   step;

    state_t     state_reg;
    logic [1:0] port_reg;
    logic [3:0] cnt_reg;
    logic [1:0] bit_cnt_reg;
    logic [3:0] p_vec;

    // First synchronizer stage samples the raw asynchronous button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= clkPB;
        end
    end

    // Remaining synchronizer stages
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            // Shift the button level one stage further down the chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Delayed copy of the synchronized level for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_reg <= 1'b0;
        end else begin
            edge_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // One-clock step pulse per press, no matter how long the button is held
    assign step = sync_reg[SYNC_STAGES-1] & ~edge_reg;

    // Frame FSM with address/count shift registers; advances only on step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            port_reg    <= 2'd0;
            cnt_reg     <= 4'd0;
            bit_cnt_reg <= 2'd0;
        end else if (step) begin
            case (state_reg)
                IDLE: begin
                    // Line idles high; a 0 is the start bit
                    if (!ser_in) begin
                        state_reg   <= PORT;
                        cnt_reg     <= 4'd0;
                        bit_cnt_reg <= 2'd0;
                    end
                end
                PORT: begin
                    port_reg <= {port_reg[0], ser_in};
                    if (bit_cnt_reg == 2'd1) begin
                        state_reg   <= COUNT;
                        bit_cnt_reg <= 2'd0;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 2'd1;
                    end
                end
                COUNT: begin
                    cnt_reg <= {cnt_reg[2:0], ser_in};
                    if (bit_cnt_reg == 2'd3) begin
                        bit_cnt_reg <= 2'd0;
                        // A zero-length frame skips the data phase entirely
                        if ({cnt_reg[2:0], ser_in} == 4'd0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= DATA;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 2'd1;
                    end
                end
                DATA: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // The bit on this step is swallowed, never a start bit
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Live routing of ser_in to the addressed port during the data phase
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_route
            assign p_vec[gi] = (state_reg == DATA) && (port_reg == 2'(gi)) && ser_in;
        end
    endgenerate

    assign p0          = p_vec[0];
    assign p1          = p_vec[1];
    assign p2          = p_vec[2];
    assign p3          = p_vec[3];
    assign SerOutValid = (state_reg == DATA);
    assign done        = (state_reg == DONE);

    // Active-high hex font, segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Display decode; common-anode panels need the font inverted
    always_comb begin
        SSD1 = hex_font(cnt_reg);
        SSD2 = hex_font({2'b00, port_reg});
        if (SSD_ACT_LOW != 0) begin
            SSD1 = ~SSD1;
            SSD2 = ~SSD2;
        end
    end

endmodule

// File: tb/tb_serial_router_system.sv
// Directed bench for serial_router_system: frames are stepped in with the
// pushbutton and outputs are sampled half a clock away from the active edge.
module tb_serial_router_system;

    logic       clk;
    logic       rst;
    logic       clkPB;
    logic       ser_in;
    logic       p0, p1, p2, p3;
    logic       SerOutValid;
    logic       done;
    logic [6:0] SSD1;
    logic [6:0] SSD2;

    int checks   = 0;
    int failures = 0;

    // Active-low segment codes for hex digits 0..F, hand-inverted from the font
    logic [6:0] ssd_lo [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    serial_router_system #(
        .SYNC_STAGES(2),
        .SSD_ACT_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clkPB      (clkPB),
        .ser_in     (ser_in),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .SerOutValid(SerOutValid),
        .done       (done),
        .SSD1       (SSD1),
        .SSD2       (SSD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One button press: ser_in set with the press, button held for 'hold' clocks,
    // then released long enough for the step to land and the synchronizer to clear
    task automatic press(input logic b, input int hold);
        @(negedge clk);
        ser_in = b;
        clkPB  = 1'b1;
        repeat (hold) @(negedge clk);
        clkPB = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pvec"}, {p3, p2, p1, p0}, 0);
        check({tag, "_valid"}, SerOutValid, 0);
    endtask

    logic [2:0]  data3 = 3'b101;
    logic [14:0] data15 = 15'b101100111000110;

    initial begin
        rst    = 1'b0;
        clkPB  = 1'b0;
        ser_in = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_pvec", {p3, p2, p1, p0}, 0);
        check("rst_valid", SerOutValid, 0);
        check("rst_done", done, 0);
        check("rst_ssd1", SSD1, 7'h40);
        check("rst_ssd2", SSD2, 7'h40);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // line idle high: three 1s keep the FSM in IDLE
        for (int i = 0; i < 3; i++) press(1'b1, 1);
        check("idle_valid", SerOutValid, 0);
        check("idle_done", done, 0);
        check("idle_ssd1", SSD1, ssd_lo[0]);

        // ---------------- frame: port 2, N=3 ----------------
        press(1'b0, 1);
        press(1'b1, 1);
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b1, 1);
        press(1'b1, 1);
        check("f1_valid", SerOutValid, 1);
        check("f1_ssd2", SSD2, ssd_lo[2]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ser_in = data3[2-i];
            #1;
            check($sformatf("f1_p2_d%0d", i), p2, int'(data3[2-i]));
            check($sformatf("f1_other_d%0d", i), {p3, p1, p0}, 0);
            check($sformatf("f1_ssd1_d%0d", i), SSD1, ssd_lo[3-i]);
            press(data3[2-i], 1);
        end
        check("f1_done", done, 1);
        check("f1_valid_end", SerOutValid, 0);
        check("f1_p2_end", p2, 0);
        check("f1_ssd1_end", SSD1, ssd_lo[0]);
        check("f1_ssd2_end", SSD2, ssd_lo[2]);
        // a 0 on the DONE step must not start a new frame
        press(1'b0, 1);
        check("f1_done_clr", done, 0);

        // ---------------- zero count: port 1, N=0 ----------------
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 1);
            check($sformatf("z_valid_%0d", i), SerOutValid, 0);
        end
        check("z_done", done, 1);
        check("z_pvec", {p3, p2, p1, p0}, 0);
        check("z_ssd1", SSD1, ssd_lo[0]);
        check("z_ssd2", SSD2, ssd_lo[1]);
        press(1'b1, 1);
        check("z_done_clr", done, 0);

        // ---------------- max count: port 3, N=15 ----------------
        press(1'b0, 1);
        press(1'b1, 1);
        press(1'b1, 1);
        for (int i = 0; i < 4; i++) press(1'b1, 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ser_in = data15[14-i];
            #1;
            check($sformatf("m_p3_d%0d", i), p3, int'(data15[14-i]));
            check($sformatf("m_other_d%0d", i), {p2, p1, p0}, 0);
            check($sformatf("m_valid_d%0d", i), SerOutValid, 1);
            check($sformatf("m_done_d%0d", i), done, 0);
            check($sformatf("m_ssd1_d%0d", i), SSD1, ssd_lo[15-i]);
            press(data15[14-i], 1);
        end
        check("m_done", done, 1);
        check("m_ssd2", SSD2, ssd_lo[3]);
        press(1'b1, 1);
        check_idle_outputs("m_after");

        // ---------------- button: long hold = one step ----------------
        press(1'b0, 50);                 // start bit, held 50 clocks
        press(1'b0, 1);                  // port bits 0,1 -> port 1
        press(1'b1, 1);
        check("btn_ssd2", SSD2, ssd_lo[1]);
        press(1'b0, 1);                  // count 0010 -> N=2
        press(1'b0, 1);
        press(1'b1, 1);
        press(1'b0, 1);
        check("btn_valid", SerOutValid, 1);
        check("btn_ssd1", SSD1, ssd_lo[2]);
        press(1'b1, 1);                  // first data bit
        check("btn_p1", p1, 1);
        check("btn_ssd1_b", SSD1, ssd_lo[1]);

        // ---------------- mid-frame reset ----------------
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_pvec", {p3, p2, p1, p0}, 0);
        check("mr_valid", SerOutValid, 0);
        check("mr_done", done, 0);
        check("mr_ssd1", SSD1, 7'h40);
        check("mr_ssd2", SSD2, 7'h40);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("mr_rel");

        // next frame after reset: port 0, N=1, data 1
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b0, 1);
        press(1'b1, 1);
        @(negedge clk);
        ser_in = 1'b1;
        #1;
        check("nf_p0", p0, 1);
        check("nf_valid", SerOutValid, 1);
        check("nf_ssd1", SSD1, ssd_lo[1]);
        check("nf_ssd2", SSD2, ssd_lo[0]);
        press(1'b1, 1);
        check("nf_done", done, 1);
        check("nf_p0_end", p0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
